counter_step_checker: RTL and testbench
=======================================

// Module: counter_step_checker
// PURPOSE
//  Downstream monitor for even_odd_up_down_counter. Taps the counter's load/mode/data_in
//  controls and its data_out, runs a cycle-accurate reference model and flags step,
//  parity and wrap events. Sits beside the counter on the same clock; output feeds
//  status/debug logic only, never back into the counter.
// PARAMETERS
//  WIDTH      4   counter data width
//  STEP       2   counter increment/decrement per clock (keeps parity)
//  ERR_W      8   width of saturating error counter
//  LOST_THR   3   consecutive mismatches that drop lock
// PORTS
//  clk        in   1      system clock; all state updates on rising edge
//  rst        in   1      synchronous, active-high reset (shared with counter)
//  en         in   1      monitor enable; 0 = freeze checking
//  load       in   1      counter load strobe (tapped)
//  mode       in   1      counter direction, 1 = up, 0 = down (tapped)
//  data_in    in   WIDTH  counter load value (tapped)
//  data_out   in   WIDTH  counter output under check
//  locked     out  1      1 = model tracking counter
//  err_pulse  out  1      one-cycle pulse per mismatch
//  err_count  out  ERR_W  saturating mismatch count
//  parity_err out  1      sticky: data_out parity differs from last load parity
//  wrap_pulse out  1      one-cycle pulse when model wraps modulo 2**WIDTH
//  state_o    out  2      FSM state for debug
// BEHAVIOUR
//  Reset: state=SYNC, exp=0, all outputs 0, consec=0, ref_par=0.
//  Model: at each edge, pred = load ? data_in : (mode ? data_out+STEP : data_out-STEP),
//   mod 2**WIDTH; load wins over mode. pred registered into exp; compared at next edge.
//  FSM (state_o: IDLE=0 SYNC=1 TRACK=2 LOST=3):
//   IDLE : en=0 from any state -> IDLE; no compare, outputs hold. en=1 -> SYNC.
//   SYNC : one cycle; seed exp=pred from current sample; -> TRACK, locked=1 next cycle.
//   TRACK: data_out!=exp -> err_pulse=1 next cycle, err_count+1 (saturate all-ones),
//          consec+1, exp reseeded from pred of observed data_out (one fault = one error).
//          match -> consec=0. consec reaches LOST_THR -> LOST, locked=0.
//   LOST : no err_pulse/count; load=1 seen -> SYNC.
//  Latency: mismatch sampled at edge N -> err_pulse high for cycle N..N+1 exactly.
//  wrap_pulse: registered; set when pred computed with load=0 and mode=1 and
//   data_out>=2**WIDTH-STEP, or mode=0 and data_out<STEP. Only in TRACK.
//  parity: ref_par=data_in[0] latched on each load; parity_err set when TRACK and
//   data_out[0]!=ref_par; cleared only by rst or a new load.
//  Simultaneous: load+mismatch same edge -> error counted, reseed uses data_in.
//   rst overrides en and everything else. rst mid-TRACK -> SYNC next cycle,
//   err_count cleared.
//  Widths: all arithmetic in WIDTH bits, natural wrap; no signed types.
// STRUCTURE
//  counter_pkg: WIDTH/STEP defaults, state encoding localparams (IDLE..LOST).
//  Sub-module step_predictor (combinational): load, mode, data_in, data_out ->
//   pred, wrap. Reused by the counter's own assertions. FSM + counters in top.
// TESTING
//  1 rst, en=1, load 3, mode=1 for 10 clk -> out 3,5,..,15,1 ; err_count=0, one wrap_pulse.
//  2 load 4, mode=0 -> 4,2,0,14 ; wrap_pulse once at 0->14, parity_err=0, locked=1.
//  3 force data_out to 7 once during up count from 4 -> one err_pulse, err_count=1, locked=1.
//  4 force 3 consecutive bad values -> state_o=3, locked=0; then load 6 -> SYNC, TRACK, locked=1.
//  5 load 5 then force an even data_out -> parity_err=1 sticky until next load.
//  6 rst mid-TRACK with err_count=2 -> next cycle err_count=0, state_o=1; en=0 -> state_o=0.

Source files
------------

// File: rtl/counter_step_checker_pkg.sv
// Shared defaults and state encoding for the counter step checker.
package counter_step_checker_pkg;

  localparam int WIDTH_DEF    = 4;
  localparam int STEP_DEF     = 2;
  localparam int ERR_W_DEF    = 8;
  localparam int LOST_THR_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_TRACK = 2'd2,
    ST_LOST  = 2'd3
  } chk_state_t;

endpackage

// File: rtl/counter_step_checker_step_predictor.sv
// Combinational next-value predictor for the even/odd up/down counter.
module step_predictor #(
  parameter int WIDTH = 4,
  parameter int STEP  = 2
) (
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] pred,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] UP_LIM = WIDTH'((1 << WIDTH) - STEP);

  // Load wins over direction; arithmetic wraps naturally in WIDTH bits.
  always_comb begin
    pred = data_in;
    wrap = 1'b0;
    if (!load) begin
      if (mode) begin
        pred = data_out + STEP_V;
        wrap = (data_out >= UP_LIM);
      end else begin
        pred = data_out - STEP_V;
        wrap = (data_out < STEP_V);
      end
    end
  end

endmodule

// File: rtl/counter_step_checker.sv
// Monitor beside the even/odd up/down counter: tracks it with a reference model
// and reports step mismatches, parity faults and wrap events.
//
// state | meaning
// IDLE  | monitor disabled, outputs hold
// SYNC  | seed expected value from the current sample
// TRACK | compare data_out against expected every cycle
// LOST  | too many consecutive misses; wait for a load to resync
module counter_step_checker
  import counter_step_checker_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int STEP     = STEP_DEF,
  parameter int ERR_W    = ERR_W_DEF,
  parameter int LOST_THR = LOST_THR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] data_out,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             parity_err,
  output logic             wrap_pulse,
  output logic [1:0]       state_o
);

  localparam int CONSEC_W = $clog2(LOST_THR + 1);
  localparam logic [CONSEC_W-1:0] MISS_RELOAD = CONSEC_W'(LOST_THR);
  localparam logic [CONSEC_W-1:0] MISS_LAST   = CONSEC_W'(1);

  chk_state_t          state;
  logic [WIDTH-1:0]    exp_val;
  logic [CONSEC_W-1:0] miss_left;
  logic                ref_par;
  logic [WIDTH-1:0]    pred;
  logic                wrap;

  step_predictor #(.WIDTH(WIDTH), .STEP(STEP)) u_pred (
    .load     (load),
    .mode     (mode),
    .data_in  (data_in),
    .data_out (data_out),
    .pred     (pred),
    .wrap     (wrap)
  );

  assign state_o = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_SYNC;
      exp_val    <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      parity_err <= 1'b0;
      wrap_pulse <= 1'b0;
      miss_left  <= MISS_RELOAD;
      ref_par    <= 1'b0;
    end else begin
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;

      // A load re-arms the parity reference even while the monitor is frozen.
      if (load) begin
        ref_par    <= data_in[0];
        parity_err <= 1'b0;
      end else if (en && state == ST_TRACK && data_out[0] != ref_par) begin
        parity_err <= 1'b1;
      end

      if (!en) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: state <= ST_SYNC;
          ST_SYNC: begin
            exp_val   <= pred;
            locked    <= 1'b1;
            miss_left <= MISS_RELOAD;
            state     <= ST_TRACK;
          end
          ST_TRACK: begin
            // Reseeding from the observed value keeps one fault to one error.
            exp_val    <= pred;
            wrap_pulse <= wrap;
            if (data_out != exp_val) begin
              err_pulse <= 1'b1;
              if (err_count != '1) err_count <= err_count + 1'b1;
              if (miss_left == MISS_LAST) begin
                state  <= ST_LOST;
                locked <= 1'b0;
              end else begin
                miss_left <= miss_left - 1'b1;
              end
            end else begin
              miss_left <= MISS_RELOAD;
            end
          end
          ST_LOST: if (load) state <= ST_SYNC;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_step_checker.sv
// Self-checking bench: a behavioural counter drives the checker, a reference model
// feeds a scoreboard queue, and directed checks cover the scenario boundaries.
module tb_counter_step_checker;

  logic       clk = 1'b0;
  logic       rst, en, load, mode;
  logic [3:0] data_in, data_out;
  logic       locked, err_pulse, parity_err, wrap_pulse;
  logic [7:0] err_count;
  logic [1:0] state_o;

  counter_step_checker dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .mode       (mode),
    .data_in    (data_in),
    .data_out   (data_out),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .parity_err (parity_err),
    .wrap_pulse (wrap_pulse),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic       lk;
    logic       ep;
    logic [7:0] ec;
    logic       pe;
    logic       wp;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int wrap_seen = 0;
  int pulse_seen = 0;

  logic [3:0] cnt = 4'd0;

  // Reference model state
  logic [1:0] m_st = 2'd0;
  logic [3:0] m_exp = 4'd0;
  logic       m_lk = 1'b0, m_ep = 1'b0, m_pe = 1'b0, m_wp = 1'b0, m_rp = 1'b0;
  logic [7:0] m_ec = 8'd0;
  int         m_consec = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic ld, input logic md,
                            input logic [3:0] din, input logic [3:0] dout);
    logic [3:0] pred;
    logic       wr;
    logic       old_rp;
    if (r) begin
      m_st = 2'd1; m_exp = 4'd0; m_lk = 1'b0; m_ep = 1'b0; m_ec = 8'd0;
      m_pe = 1'b0; m_wp = 1'b0; m_consec = 0; m_rp = 1'b0;
    end else begin
      pred   = ld ? din : (md ? dout + 4'd2 : dout - 4'd2);
      wr     = !ld && (md ? (dout >= 4'd14) : (dout < 4'd2));
      old_rp = m_rp;
      m_ep = 1'b0;
      m_wp = 1'b0;
      if (ld) begin
        m_rp = din[0];
        m_pe = 1'b0;
      end else if (e && m_st == 2'd2 && dout[0] != old_rp) begin
        m_pe = 1'b1;
      end
      if (!e) m_st = 2'd0;
      else begin
        case (m_st)
          2'd0: m_st = 2'd1;
          2'd1: begin m_exp = pred; m_lk = 1'b1; m_consec = 0; m_st = 2'd2; end
          2'd2: begin
            m_wp = wr;
            if (dout != m_exp) begin
              m_ep = 1'b1;
              if (m_ec != 8'd255) m_ec = m_ec + 8'd1;
              m_consec++;
              if (m_consec >= 3) begin m_st = 2'd3; m_lk = 1'b0; end
            end else m_consec = 0;
            m_exp = pred;
          end
          default: if (ld) m_st = 2'd1;
        endcase
      end
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic ld, input logic md,
                       input logic [3:0] din);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; load = ld; mode = md; data_in = din; data_out = cnt;
    model_step(r, e, ld, md, din, cnt);
    sb_q.push_back('{st: m_st, lk: m_lk, ep: m_ep, ec: m_ec, pe: m_pe, wp: m_wp});
    if (r) cnt = 4'd0;
    else if (ld) cnt = din;
    else cnt = md ? cnt + 4'd2 : cnt - 4'd2;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      x = sb_q.pop_front();
      check("sb_state", state_o, x.st);
      check("sb_locked", locked, x.lk);
      check("sb_err_pulse", err_pulse, x.ep);
      check("sb_err_count", err_count, x.ec);
      check("sb_parity", parity_err, x.pe);
      check("sb_wrap", wrap_pulse, x.wp);
    end
    if (wrap_pulse === 1'b1) wrap_seen++;
    if (err_pulse === 1'b1) pulse_seen++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; mode = 1'b0; data_in = 4'd0; data_out = 4'd0;

    cycle(1, 1, 0, 1, 0);
    check("rst_state", state_o, 1);
    check("rst_locked", locked, 0);
    check("rst_err_count", err_count, 0);

    // 1: load 3, count up with one wrap at 15 -> 1
    cycle(0, 1, 1, 1, 3);
    wrap_seen = 0;
    repeat (10) cycle(0, 1, 0, 1, 0);
    check("t1_wraps", wrap_seen, 1);
    check("t1_err_count", err_count, 0);
    check("t1_locked", locked, 1);

    // 2: load 4, count down 4,2,0,14
    wrap_seen = 0;
    cycle(0, 1, 1, 0, 4);
    repeat (4) cycle(0, 1, 0, 0, 0);
    check("t2_wraps", wrap_seen, 1);
    check("t2_parity", parity_err, 0);
    check("t2_locked", locked, 1);

    // 3: single glitch to 7 while counting up from 4
    pulse_seen = 0;
    cycle(0, 1, 1, 1, 4);
    repeat (2) cycle(0, 1, 0, 1, 0);
    cnt = 4'd7;
    repeat (4) cycle(0, 1, 0, 1, 0);
    check("t3_pulses", pulse_seen, 1);
    check("t3_err_count", err_count, 1);
    check("t3_locked", locked, 1);

    // 4: three consecutive bad values drop lock, load 6 resyncs
    repeat (3) begin
      cnt = cnt + 4'd1;
      cycle(0, 1, 0, 1, 0);
    end
    check("t4_state_lost", state_o, 3);
    check("t4_locked_lost", locked, 0);
    cycle(0, 1, 1, 1, 6);
    check("t4_state_sync", state_o, 1);
    cycle(0, 1, 0, 1, 0);
    check("t4_state_track", state_o, 2);
    check("t4_relocked", locked, 1);
    cycle(0, 1, 0, 1, 0);
    check("t4_err_count", err_count, 4);

    // 5: odd load then even value -> sticky parity until next load
    cycle(0, 1, 1, 1, 5);
    repeat (2) cycle(0, 1, 0, 1, 0);
    cnt = 4'd8;
    cycle(0, 1, 0, 1, 0);
    check("t5_parity_set", parity_err, 1);
    repeat (2) cycle(0, 1, 0, 1, 0);
    check("t5_parity_sticky", parity_err, 1);
    cycle(0, 1, 1, 1, 3);
    check("t5_parity_clear", parity_err, 0);

    // 6: two separated faults, then reset mid-TRACK and disable
    cycle(1, 1, 0, 1, 0);
    cycle(0, 1, 1, 1, 1);
    repeat (2) cycle(0, 1, 0, 1, 0);
    cnt = cnt + 4'd1;
    repeat (3) cycle(0, 1, 0, 1, 0);
    cnt = cnt + 4'd1;
    repeat (2) cycle(0, 1, 0, 1, 0);
    check("t6_err_count", err_count, 2);
    check("t6_state_track", state_o, 2);
    cycle(1, 1, 0, 1, 0);
    check("t6_rst_err_count", err_count, 0);
    check("t6_rst_state", state_o, 1);
    cycle(0, 0, 0, 1, 0);
    check("t6_idle", state_o, 0);
    cycle(0, 1, 0, 1, 0);
    check("t6_resync", state_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
